bz_worm_deserializer: RTL and testbench

Parametrised flit-to-word deserializer for the BrainZ router egress path. It pops flits from a show-ahead FIFO and strips the optional worm header. It assembles NFlit data flits per core word and presents each word on a Channel to the core. Unlike the fixed 3-flit predecessor, it decouples assembly from output with a registered output word, so it keeps collecting while the core stalls, and it detects malformed worms.

---
 rtl/bz_router_pkg.sv | 27 ++
 rtl/bz_channel.sv | 12 +
 rtl/bz_worm_deserializer_assembler.sv | 57 +++++
 rtl/bz_worm_deserializer.sv | 151 +++++++++++++++
 tb/tb_bz_worm_deserializer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bz_router_pkg.sv
// Shared types and defaults for the BrainZ router egress deserializer.
// Contents: flit struct (default widths), FSM state enum, default width
// parameters and the elaboration-time bound check on NFlit*NFlitData.
package bz_router_pkg;

  localparam int unsigned DefNPCcode   = 8;
  localparam int unsigned DefNPCdata   = 24;
  localparam int unsigned DefNFlitData = 10;
  localparam int unsigned DefNFlit     = 3;
  localparam int unsigned DefWordW     = DefNPCcode + DefNPCdata;

  typedef struct packed {
    logic [DefNFlitData-1:0] payload;
    logic                    tail;
  } flit_t;

  typedef enum logic [0:0] {
    StHdr,
    StCollect
  } state_e;

  // True when NFlit data flits fit into one core word.
  function automatic bit nflit_ok(int unsigned nflit, int unsigned nfd, int unsigned ww);
    return (nflit >= 1) && (nflit * nfd <= ww);
  endfunction

endpackage

// File: rtl/bz_channel.sv
// Channel: valid/accept link carrying one core word.
//   d : word, v : valid (driven by source), a : accept (driven by sink).
interface Channel #(
  parameter int unsigned W = 32
) ();
  logic [W-1:0] d;
  logic         v;
  logic         a;

  modport src (output d, output v, input a);
  modport dst (input d, input v, output a);
endinterface

// File: rtl/bz_worm_deserializer_assembler.sv
// bz_flit_assembler: holds the flit index and the partial word.
//   clk, reset : clock, synchronous active-high reset
//   load_i     : store payload_i in the slot for the current index, advance index
//   clear_i    : drop the partial word, index back to 0 (wins over load_i)
//   payload_i  : payload of the FIFO head flit
//   word_o     : partial word with payload_i merged into the current slot
//   last_o     : current index is the final flit of a word
module bz_flit_assembler
  import bz_router_pkg::*;
#(
  parameter int unsigned NFlitData = DefNFlitData,
  parameter int unsigned NFlit     = DefNFlit,
  parameter int unsigned WordW     = DefWordW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 clear_i,
  input  logic [NFlitData-1:0] payload_i,
  output logic [WordW-1:0]     word_o,
  output logic                 last_o
);

  localparam int unsigned IdxW = (NFlit > 1) ? $clog2(NFlit) : 1;
  localparam int unsigned AsmW = NFlit * NFlitData;

  logic [IdxW-1:0] idx_q, idx_d;
  logic [AsmW-1:0] asm_q, asm_d;
  logic [AsmW-1:0] slot;

  // First flit is most significant: index k sits (NFlit-1-k) slots up.
  always_comb begin
    slot   = AsmW'(payload_i) << (NFlitData * (NFlit - 1 - 32'(idx_q)));
    word_o = WordW'(asm_q | slot);
    last_o = (32'(idx_q) == NFlit - 1);
    asm_d  = asm_q;
    idx_d  = idx_q;
    if (clear_i) begin
      asm_d = '0;
      idx_d = '0;
    end else if (load_i) begin
      asm_d = asm_q | slot;
      idx_d = idx_q + IdxW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      asm_q <= '0;
      idx_q <= '0;
    end else begin
      asm_q <= asm_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/bz_worm_deserializer.sv
// bz_worm_deserializer: pops flits from a show-ahead FIFO, strips the optional
// worm header, assembles NFlit flits per core word and presents each word on a
// registered Channel output, flagging worms that end mid-word.
//   clk, reset      : clock, synchronous active-high reset
//   PC_out_channel  : core output Channel (d, v driven; a sampled)
//   isempty         : FIFO empty flag
//   data_in         : FIFO head, [NFlitData:1] payload, [0] tail
//   rdreq           : pop FIFO head this cycle
//   proto_err       : one-cycle pulse on premature tail
// Build option BZ_DESER_STATS_EN adds word_count[31:0] and err_count[15:0].
module bz_worm_deserializer
  import bz_router_pkg::*;
#(
  parameter int unsigned NPCcode   = DefNPCcode,
  parameter int unsigned NPCdata   = DefNPCdata,
  parameter int unsigned NFlitData = DefNFlitData,
  parameter int unsigned NFlit     = DefNFlit,
  parameter bit          HasHeader = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  Channel.src                  PC_out_channel,
  input  logic                 isempty,
  input  logic [NFlitData:0]   data_in,
  output logic                 rdreq,
  output logic                 proto_err
`ifdef BZ_DESER_STATS_EN
  ,
  output logic [31:0]          word_count,
  output logic [15:0]          err_count
`endif
);

  localparam int unsigned WordW = NPCcode + NPCdata;
  localparam state_e InitSt = HasHeader ? StHdr : StCollect;

  if (!nflit_ok(NFlit, NFlitData, WordW)) begin : g_bad_cfg
    $error("bz_worm_deserializer: NFlit*NFlitData must fit the core word and NFlit >= 1");
  end

  state_e             state_q;
  logic               out_v_q;
  logic [WordW-1:0]   out_d_q;
  logic               err_q;

  logic [NFlitData-1:0] payload;
  logic                 tail;
  logic                 last;
  logic [WordW-1:0]     word;
  logic                 xfer;
  logic                 asm_load;
  logic                 asm_clear;

  assign payload = data_in[NFlitData:1];
  assign tail    = data_in[0];
  assign xfer    = out_v_q && PC_out_channel.a;

  // The final flit waits in the FIFO until the output register can take it.
  always_comb begin
    rdreq = 1'b0;
    if (!reset && !isempty) begin
      if (state_q == StHdr || !last) begin
        rdreq = 1'b1;
      end else begin
        rdreq = !out_v_q || xfer;
      end
    end
  end

  assign asm_load  = rdreq && (state_q == StCollect) && !last && !tail;
  assign asm_clear = rdreq && (state_q == StCollect) && (last || tail);

  bz_flit_assembler #(
    .NFlitData (NFlitData),
    .NFlit     (NFlit),
    .WordW     (WordW)
  ) u_assembler (
    .clk       (clk),
    .reset     (reset),
    .load_i    (asm_load),
    .clear_i   (asm_clear),
    .payload_i (payload),
    .word_o    (word),
    .last_o    (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= InitSt;
      out_v_q <= 1'b0;
      out_d_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (xfer) begin
        out_v_q <= 1'b0;
      end
      if (rdreq) begin
        unique case (state_q)
          StHdr: begin
            // A header with tail set is an empty worm: stay for the next header.
            if (!tail) begin
              state_q <= StCollect;
            end
          end
          StCollect: begin
            if (last) begin
              // Reload wins over the clear from a same-cycle transfer.
              out_v_q <= 1'b1;
              out_d_q <= word;
              if (tail) begin
                state_q <= InitSt;
              end
            end else if (tail) begin
              err_q   <= 1'b1;
              state_q <= InitSt;
            end
          end
          default: state_q <= InitSt;
        endcase
      end
    end
  end

  assign PC_out_channel.v = out_v_q;
  assign PC_out_channel.d = out_d_q;
  assign proto_err        = err_q;

`ifdef BZ_DESER_STATS_EN
  logic [31:0] word_cnt_q;
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (xfer) begin
        word_cnt_q <= word_cnt_q + 32'd1;
      end
      if (err_q && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign word_count = word_cnt_q;
  assign err_count  = err_cnt_q;
`endif

endmodule

// File: tb/tb_bz_worm_deserializer.sv
module tb_bz_worm_deserializer;
  import bz_router_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        isempty0, isempty1, rdreq0, rdreq1, perr0, perr1;
  logic [10:0] din0;
  logic [12:0] din1;
`ifdef BZ_DESER_STATS_EN
  logic [31:0] wc0, wc1;
  logic [15:0] ec0, ec1;
`endif

  Channel #(.W(W)) ch0 ();
  Channel #(.W(W)) ch1 ();

  bz_worm_deserializer u_dut0 (
    .clk            (clk),
    .reset          (reset),
    .PC_out_channel (ch0),
    .isempty        (isempty0),
    .data_in        (din0),
    .rdreq          (rdreq0),
    .proto_err      (perr0)
`ifdef BZ_DESER_STATS_EN
    ,
    .word_count     (wc0),
    .err_count      (ec0)
`endif
  );

  bz_worm_deserializer #(
    .NFlitData (12),
    .NFlit     (2),
    .HasHeader (1'b0)
  ) u_dut1 (
    .clk            (clk),
    .reset          (reset),
    .PC_out_channel (ch1),
    .isempty        (isempty1),
    .data_in        (din1),
    .rdreq          (rdreq1),
    .proto_err      (perr1)
`ifdef BZ_DESER_STATS_EN
    ,
    .word_count     (wc1),
    .err_count      (ec1)
`endif
  );

  // Source FIFO models and scoreboards.
  logic [10:0] fifo0[$];
  logic [12:0] fifo1[$];
  logic [31:0] sb0[$];
  logic [31:0] sb1[$];

  int checks = 0, passes = 0, viol = 0;
  int err_seen0 = 0, err_seen1 = 0, err_exp0 = 0;
  int words_rst0 = 0, errs_rst0 = 0;
  bit arand0 = 1'b0, arand1 = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic void refresh();
    isempty0 = (fifo0.size() == 0);
    din0     = isempty0 ? 11'd0 : fifo0[0];
    isempty1 = (fifo1.size() == 0);
    din1     = isempty1 ? 13'd0 : fifo1[0];
  endfunction

  // FIFO pop and accept driver: decide at negedge, apply just after posedge.
  bit pop0, pop1;
  logic [12:0] junk;
  always begin
    @(negedge clk);
    pop0 = rdreq0 && !isempty0;
    pop1 = rdreq1 && !isempty1;
    if (rdreq0 && isempty0) viol++;
    if (rdreq1 && isempty1) viol++;
    @(posedge clk);
    #1;
    if (pop0) junk = 13'(fifo0.pop_front());
    if (pop1) junk = fifo1.pop_front();
    if (arand0) ch0.a = 1'($urandom_range(0, 1));
    if (arand1) ch1.a = 1'($urandom_range(0, 1));
    refresh();
  end

  // Monitor: compares every transfer with the scoreboard, watches v/d hold.
  bit          hold0 = 1'b0, hold1 = 1'b0;
  logic [31:0] pd0, pd1;
  always @(negedge clk) begin
    if (perr0) err_seen0++;
    if (perr1) err_seen1++;
    if (hold0 && (!ch0.v || ch0.d !== pd0)) viol++;
    if (hold1 && (!ch1.v || ch1.d !== pd1)) viol++;
    if (ch0.v && ch0.a && !reset) begin
      if (sb0.size() == 0) begin
        checks++;
        $display("FAIL unexpected_word0: got 0x%0h expected none", ch0.d);
      end else check("word0", 64'(ch0.d), 64'(sb0.pop_front()));
    end
    if (ch1.v && ch1.a && !reset) begin
      if (sb1.size() == 0) begin
        checks++;
        $display("FAIL unexpected_word1: got 0x%0h expected none", ch1.d);
      end else check("word1", 64'(ch1.d), 64'(sb1.pop_front()));
    end
    hold0 = ch0.v && !ch0.a && !reset;
    hold1 = ch1.v && !ch1.a && !reset;
    pd0   = ch0.d;
    pd1   = ch1.d;
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(string name, int budget);
    int n = 0;
    while ((sb0.size() + sb1.size() + fifo0.size() + fifo1.size()) != 0 && n < budget) begin
      tick(1);
      n++;
    end
    tick(3);
    check({name, "_drain"}, 64'(n < budget), 64'd1);
    if (n >= budget) begin
      sb0.delete(); sb1.delete(); fifo0.delete(); fifo1.delete();
      refresh();
    end
  endtask

  task automatic hdr0(bit t);
    fifo0.push_back({10'($urandom), t});
    refresh();
  endtask

  // Split a 30-bit word into three flits, most significant first.
  task automatic send0(logic [29:0] w, bit tail_last);
    for (int k = 0; k < 3; k++) fifo0.push_back({w[(2-k)*10 +: 10], (k == 2) && tail_last});
    sb0.push_back({2'b00, w});
    words_rst0++;
    refresh();
  endtask

  logic [29:0] w1, w2;
  logic [23:0] wx;
  int          n_err_words;

  initial begin
    reset = 1'b1;
    ch0.a = 1'b1;
    ch1.a = 1'b1;
    refresh();
    tick(3);
    check("rst_v0", 64'(ch0.v), 64'd0);
    check("rst_d0", 64'(ch0.d), 64'd0);
    check("rst_perr0", 64'(perr0), 64'd0);
    check("rst_v1", 64'(ch1.v), 64'd0);
    reset = 1'b0;
    tick(1);

    // Single word, header payload 0.
    fifo0.push_back(11'h000);
    send0(30'h3FF00155, 1'b1);
    wait_idle("t1", 200);
    check("t1_fsm_hdr", 64'(u_dut0.state_q), 64'(StHdr));

    // Two-word worm.
    hdr0(1'b0);
    send0(30'h00100803, 1'b0);
    send0(30'h00401406, 1'b1);
    wait_idle("t2", 200);
    check("t2_no_err", 64'(err_seen0), 64'(err_exp0));

    // Backpressure: final flit of word 2 must stay in the FIFO.
    ch0.a = 1'b0;
    w1 = 30'($urandom);
    w2 = 30'($urandom);
    hdr0(1'b0);
    send0(w1, 1'b0);
    send0(w2, 1'b1);
    tick(20);
    check("bp_v", 64'(ch0.v), 64'd1);
    check("bp_d_hold", 64'(ch0.d), 64'({2'b00, w1}));
    check("bp_fifo_left", 64'(fifo0.size()), 64'd1);
    check("bp_rdreq", 64'(rdreq0), 64'd0);
    ch0.a = 1'b1;
    tick(1);
    check("bp_v_stays", 64'(ch0.v), 64'd1);
    check("bp_reload_d", 64'(ch0.d), 64'({2'b00, w2}));
    wait_idle("t3", 200);

    // Premature tail, then a clean worm.
    hdr0(1'b0);
    fifo0.push_back({10'h0AA, 1'b0});
    fifo0.push_back({10'h0BB, 1'b1});
    err_exp0++;
    hdr0(1'b0);
    send0(30'($urandom), 1'b1);
    wait_idle("t4", 200);
    check("t4_err_pulses", 64'(err_seen0), 64'(err_exp0));

    // Reset mid-word.
    hdr0(1'b0);
    fifo0.push_back({10'h3FF, 1'b0});
    fifo0.push_back({10'h3FF, 1'b0});
    refresh();
    wait_idle("t5_pre", 200);
    reset = 1'b1;
    fifo0.push_back({10'h3FF, 1'b0});
    refresh();
    @(negedge clk);
    check("rst_rdreq_pre", 64'(rdreq0), 64'd0);
    tick(1);
    check("rst_mid_v", 64'(ch0.v), 64'd0);
    check("rst_mid_rdreq", 64'(rdreq0), 64'd0);
    reset = 1'b0;
    words_rst0 = 0;
    errs_rst0  = 0;
    send0(30'($urandom), 1'b1);
    wait_idle("t5", 200);

    // Random worms with random accept.
    arand0 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      int  nw;
      bit  partial;
      nw      = int'($urandom_range(0, 2));
      partial = ($urandom_range(0, 3) == 0);
      hdr0(nw == 0 && !partial);
      for (int j = 0; j < nw; j++) send0(30'($urandom), (j == nw - 1) && !partial);
      if (partial) begin
        n_err_words = int'($urandom_range(1, 2));
        for (int j = 0; j < n_err_words; j++)
          fifo0.push_back({10'($urandom), j == n_err_words - 1});
        err_exp0++;
        errs_rst0++;
        refresh();
      end
    end
    wait_idle("rand0", 3000);
    arand0 = 1'b0;
    ch0.a  = 1'b1;
    tick(2);
    check("rand0_err_pulses", 64'(err_seen0), 64'(err_exp0));

    // Headerless 2x12 configuration, 100 back-to-back words.
    arand1 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wx = 24'($urandom);
      fifo1.push_back({wx[23:12], 1'b0});
      fifo1.push_back({wx[11:0], (i == 99) || ($urandom_range(0, 2) == 0)});
      sb1.push_back({8'h00, wx});
    end
    refresh();
    wait_idle("t6", 3000);
    arand1 = 1'b0;
    ch1.a  = 1'b1;
    tick(2);
    check("t6_no_err", 64'(err_seen1), 64'd0);
`ifdef BZ_DESER_STATS_EN
    check("t6_word_count", 64'(wc1), 64'd100);
    check("t6_err_count", 64'(ec1), 64'd0);
    check("dut0_word_count", 64'(wc0), 64'(words_rst0));
    check("dut0_err_count", 64'(ec0), 64'(errs_rst0));
`endif
    check("protocol_violations", 64'(viol), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
